// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the fuzzy controller rule-firing stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fuzzy_pkg;

   localparam int W       = 8;     // grade width
   localparam int TOPO    = 100;   // full-membership grade value
   localparam int N_SETS  = 3;     // fuzzy sets per input
   localparam int N_RULES = 9;     // N_SETS * N_SETS

   localparam logic [3:0] LAST_RULE = 4'(N_RULES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_EMIT = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // i selects the x1 set, j selects the x2 set
   typedef struct packed {
      logic [1:0] i;
      logic [1:0] j;
   } rule_ij_t;

   // Rule number r = 3*i + j split back into its (i, j) pair
   function automatic rule_ij_t rule_ij(input logic [3:0] r);
      rule_ij_t ij;
      case (r)
         4'd0:    ij = '{i: 2'd0, j: 2'd0};
         4'd1:    ij = '{i: 2'd0, j: 2'd1};
         4'd2:    ij = '{i: 2'd0, j: 2'd2};
         4'd3:    ij = '{i: 2'd1, j: 2'd0};
         4'd4:    ij = '{i: 2'd1, j: 2'd1};
         4'd5:    ij = '{i: 2'd1, j: 2'd2};
         4'd6:    ij = '{i: 2'd2, j: 2'd0};
         4'd7:    ij = '{i: 2'd2, j: 2'd1};
         4'd8:    ij = '{i: 2'd2, j: 2'd2};
         default: ij = '{i: 2'd0, j: 2'd0};
      endcase
      return ij;
   endfunction

endpackage

// File: rtl/min_grade.sv
// Two-input unsigned minimum of membership grades (min t-norm).
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module min_grade
   import fuzzy_pkg::*;
(
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   // Unsigned compare; ties return a (identical value either way)
   always_comb begin
      y = (a <= b) ? a : b;
   end

endmodule

// File: rtl/fou_rule_firing.sv
// Rule firing: latches 12 FOU grades + activity mask, streams min-t-norm firing intervals for rules 0..8.
// Latency: START at edge 0 -> first OUT_VALID in cycle 2; 2 cycles per emitted rule, 1 per skipped rule; DONE after last rule.
// Backpressure: OUT_VALID/data held until OUT_READY; scan stalls in EMIT. Macro ZERO_SKIP_EN skips rules the mask marks inactive.
module fou_rule_firing
   import fuzzy_pkg::*;
(
   input  logic         CLK,
   input  logic         RESET,
   input  logic         START,
   input  logic [W-1:0] FOU_01_UP,
   input  logic [W-1:0] FOU_02_UP,
   input  logic [W-1:0] FOU_03_UP,
   input  logic [W-1:0] FOU_01_LOW,
   input  logic [W-1:0] FOU_02_LOW,
   input  logic [W-1:0] FOU_03_LOW,
   input  logic [W-1:0] FOU_04_UP,
   input  logic [W-1:0] FOU_05_UP,
   input  logic [W-1:0] FOU_06_UP,
   input  logic [W-1:0] FOU_04_LOW,
   input  logic [W-1:0] FOU_05_LOW,
   input  logic [W-1:0] FOU_06_LOW,
   input  logic [5:0]   Ativo_UP,
   input  logic         OUT_READY,
   output logic         OUT_VALID,
   output logic [3:0]   RULE_IDX,
   output logic [W-1:0] F_UP,
   output logic [W-1:0] F_LOW,
   output logic         BUSY,
   output logic         DONE
);

   state_t      state;
   logic [3:0]  idx;
   logic [5:0]  mask_q;
   logic [W-1:0] x1_up_q  [N_SETS];
   logic [W-1:0] x1_low_q [N_SETS];
   logic [W-1:0] x2_up_q  [N_SETS];
   logic [W-1:0] x2_low_q [N_SETS];

   rule_ij_t     ij;
   logic [W-1:0] sel_x1_up;
   logic [W-1:0] sel_x1_low;
   logic [W-1:0] sel_x2_up;
   logic [W-1:0] sel_x2_low;
   logic         x1_act;
   logic         x2_act;
   logic         rule_act;
   logic [W-1:0] min_up;
   logic [W-1:0] min_low;

   // 3:1 muxes: pick the x1 grades/mask bit for set i and the x2 ones for set j
   always_comb begin
      ij = rule_ij(idx);
      case (ij.i)
         2'd0:    begin sel_x1_up = x1_up_q[0]; sel_x1_low = x1_low_q[0]; x1_act = mask_q[5]; end
         2'd1:    begin sel_x1_up = x1_up_q[1]; sel_x1_low = x1_low_q[1]; x1_act = mask_q[4]; end
         default: begin sel_x1_up = x1_up_q[2]; sel_x1_low = x1_low_q[2]; x1_act = mask_q[3]; end
      endcase
      case (ij.j)
         2'd0:    begin sel_x2_up = x2_up_q[0]; sel_x2_low = x2_low_q[0]; x2_act = mask_q[2]; end
         2'd1:    begin sel_x2_up = x2_up_q[1]; sel_x2_low = x2_low_q[1]; x2_act = mask_q[1]; end
         default: begin sel_x2_up = x2_up_q[2]; sel_x2_low = x2_low_q[2]; x2_act = mask_q[0]; end
      endcase
`ifdef ZERO_SKIP_EN
      rule_act = x1_act & x2_act;
`else
      // Every rule is emitted; the mask term is kept only so the latched mask stays observable
      rule_act = (x1_act & x2_act) | 1'b1;
`endif
   end

   min_grade u_min_up (
      .a (sel_x1_up),
      .b (sel_x2_up),
      .y (min_up)
   );

   min_grade u_min_low (
      .a (sel_x1_low),
      .b (sel_x2_low),
      .y (min_low)
   );

   // Scan FSM with registered outputs; grades and mask are frozen at START
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= ST_IDLE;
         idx       <= 4'd0;
         mask_q    <= 6'd0;
         OUT_VALID <= 1'b0;
         RULE_IDX  <= 4'd0;
         F_UP      <= '0;
         F_LOW     <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         for (int k = 0; k < N_SETS; k++) begin
            x1_up_q[k]  <= '0;
            x1_low_q[k] <= '0;
            x2_up_q[k]  <= '0;
            x2_low_q[k] <= '0;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (START) begin
                  x1_up_q[0]  <= FOU_01_UP;
                  x1_up_q[1]  <= FOU_02_UP;
                  x1_up_q[2]  <= FOU_03_UP;
                  x1_low_q[0] <= FOU_01_LOW;
                  x1_low_q[1] <= FOU_02_LOW;
                  x1_low_q[2] <= FOU_03_LOW;
                  x2_up_q[0]  <= FOU_04_UP;
                  x2_up_q[1]  <= FOU_05_UP;
                  x2_up_q[2]  <= FOU_06_UP;
                  x2_low_q[0] <= FOU_04_LOW;
                  x2_low_q[1] <= FOU_05_LOW;
                  x2_low_q[2] <= FOU_06_LOW;
                  mask_q      <= Ativo_UP;
                  idx         <= 4'd0;
                  BUSY        <= 1'b1;
                  state       <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (rule_act) begin
                  RULE_IDX  <= idx;
                  F_UP      <= min_up;
                  F_LOW     <= min_low;
                  OUT_VALID <= 1'b1;
                  state     <= ST_EMIT;
               end else if (idx == LAST_RULE) begin
                  DONE  <= 1'b1;
                  state <= ST_FIN;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            ST_EMIT: begin
               if (OUT_READY) begin
                  OUT_VALID <= 1'b0;
                  if (idx == LAST_RULE) begin
                     DONE  <= 1'b1;
                     state <= ST_FIN;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= ST_SCAN;
                  end
               end
            end
            default: begin
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fou_rule_firing.md
# fou_rule_firing

Rule-firing stage of the interval type-2 fuzzy controller, directly downstream of the fuzzification (FOU) stage. It latches the 12 upper/lower membership grades and the 6-bit upper-activity mask produced by fuzzification, then walks the 3×3 rule base. For each rule it computes the firing interval with the min t-norm and streams the results over a valid/ready handshake to the type-reduction stage. It pulses DONE when the scan is complete.

## Interface
- W, 8, grade width in bits
- TOPO, 100, full-membership grade value; informational, used only by the bench
- CLK  in  1  clock; all state updates on the rising edge
- RESET  in  1  asynchronous, active-low reset
- START  in  1  starts one scan; sampled only in IDLE
- FOU_01_UP..FOU_03_UP, FOU_01_LOW..FOU_03_LOW  in  W each  x1 grades for sets 1..3
- FOU_04_UP..FOU_06_UP, FOU_04_LOW..FOU_06_LOW  in  W each  x2 grades for sets 1..3
- Ativo_UP  in  6  activity mask; [5:3] = x1 sets 1..3 (bit5 = set 1), [2:0] = x2 sets 1..3 (bit2 = set 1)
- OUT_READY  in  1  downstream accepts the current rule
- OUT_VALID  out  1  RULE_IDX/F_UP/F_LOW are valid
- RULE_IDX  out  4  rule number r = 3*i + j; i = x1 set (0..2), j = x2 set (0..2)
- F_UP  out  W  min(x1 upper grade i, x2 upper grade j)
- F_LOW  out  W  min(x1 lower grade i, x2 lower grade j)
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse at the end of a scan

## Operation
- States: IDLE, SCAN, EMIT, FIN.
- IDLE: when START=1, capture all 12 grades and the mask into internal registers, clear the index to 0, and go to SCAN. Input changes after capture do not affect the scan.
- SCAN: evaluate the rule at the current index. The rule is active when mask bit for x1 set i AND mask bit for x2 set j are both 1.
  - Active rule: load RULE_IDX, F_UP, F_LOW; set OUT_VALID; go to EMIT.
  - Inactive rule: if index = 8, go to FIN; otherwise increment the index and stay in SCAN.
- EMIT: hold OUT_VALID and data until OUT_READY=1. On the handshake, clear OUT_VALID; go to FIN if index = 8, otherwise increment the index and go to SCAN.
- FIN: DONE=1 for one cycle, then go to IDLE.
- Arithmetic: unsigned 8-bit min. Grades are not clamped or reordered. If F_LOW > F_UP, both pass through unchanged.
- START outside IDLE is ignored; no queuing.
- Rule order is always ascending 0..8.

## Timing
- Reset values: OUT_VALID=0, RULE_IDX=0, F_UP=0, F_LOW=0, BUSY=0, DONE=0; state IDLE; index 0.
- START accepted at edge 0 → SCAN of rule 0 in cycle 1 → first OUT_VALID in cycle 2 at the earliest.
- Each active rule costs 2 cycles plus stall cycles. Each inactive rule costs 1 cycle (with ZERO_SKIP_EN).
- DONE falls in the cycle after the last SCAN/EMIT cycle. BUSY drops in the cycle after DONE.
- RESET assertion at any point forces reset values immediately, including mid-EMIT. Any partial scan is discarded.
- OUT_VALID never deasserts without a handshake. Data is stable while OUT_VALID=1 and OUT_READY=0.

## Configuration
- ZERO_SKIP_EN defined: inactive rules are skipped as described above.
- ZERO_SKIP_EN undefined: every rule 0..8 is emitted regardless of the mask, with F_UP/F_LOW computed from the latched grades. A full scan is 9 handshakes. The mask is still latched but unused.

## Structure
- Shared package fuzzy_pkg: W, TOPO, N_SETS=3, N_RULES=9, the state encoding, and the rule-index to (i,j) mapping function.
- One sub-module, min_grade: 2-input W-bit unsigned minimum. It is instanced twice (upper and lower paths), fed by 3:1 muxes on i and j.

## Test plan
- Inputs: x1 UP 80,40,0 / LOW 60,20,0; x2 UP 30,90,0 / LOW 10,70,0; mask 6'b110110; READY=1 → four outputs: r0 (30,10), r1 (80,60), r3 (30,10), r4 (40,20); single DONE pulse.
- Mask 6'b010010, READY=1, START at edge 0 → only rule 4 emitted, OUT_VALID in cycle 6, DONE in cycle 11.
- Mask 6'b000000 → no OUT_VALID; DONE in cycle 10. With ZERO_SKIP_EN undefined → 9 outputs, idx 0..8.
- READY held low 5 cycles on rule 0 → OUT_VALID and data constant; the scan resumes on the first READY=1.
- RESET pulsed low during EMIT of rule 1 → all outputs 0 at once; a new START scans from rule 0.
- START pulsed while BUSY=1 → ignored; exactly one DONE.
